xillybus_lite_regbank: RTL and testbench

//  Parametrised register bank behind the xillybus_lite user port (user_addr/user_wren/user_rden...).

---
 rtl/xillybus_lite_regbank_pkg.sv | 28 ++
 rtl/xlite_sync_fifo.sv | 55 +++++
 rtl/xillybus_lite_regbank.sv | 136 +++++++++++++
 tb/tb_xillybus_lite_regbank.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/xillybus_lite_regbank_pkg.sv
// rtl/xillybus_lite_regbank_pkg.sv - word map, FIFO_STAT layout and byte-lane merge helper
package xillybus_lite_regbank_pkg;

  localparam logic [7:0] ADDR_ID         = 8'h00;
  localparam logic [7:0] ADDR_IRQ_STATUS = 8'h01;
  localparam logic [7:0] ADDR_IRQ_MASK   = 8'h02;
  localparam logic [7:0] ADDR_FIFO_STAT  = 8'h03;
  localparam logic [7:0] ADDR_FIFO_DATA  = 8'h04;
  localparam logic [7:0] ADDR_CTRL_BASE  = 8'h10;
  localparam logic [7:0] ADDR_STAT_BASE  = 8'h20;

  localparam int FSTAT_LEVEL_W   = 16;
  localparam int FSTAT_EMPTY_BIT = 16;
  localparam int FSTAT_FULL_BIT  = 17;
  localparam int FSTAT_OVF_BIT   = 18;

  // Byte b of the result comes from new_v when strb[b] is set, otherwise from old_v.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/xlite_sync_fifo.sv
// rtl/xlite_sync_fifo.sv - single-clock FIFO with registered pop data
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module xlite_sync_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !push_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
      if (pop_i) rd_data_q <= pop_ok ? mem_q[rd_ptr_q] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = rd_data_q;
  assign level_o    = level_q;

endmodule

// File: rtl/xillybus_lite_regbank.sv
// rtl/xillybus_lite_regbank.sv - register bank, W1C interrupt controller and readout FIFO window
module xillybus_lite_regbank
  import xillybus_lite_regbank_pkg::*;
#(
  parameter int                     NUM_CTRL   = 8,
  parameter int                     NUM_STAT   = 8,
  parameter int                     NUM_IRQ    = 16,
  parameter int                     FIFO_DEPTH = 64,
  parameter logic [NUM_CTRL*32-1:0] CTRL_RESET = '0,
  parameter logic [31:0]            VERSION    = 32'h0001_0000
) (
  input  logic                     user_clk,
  input  logic                     bus_rst_n,
  input  logic [31:0]              user_addr,
  input  logic                     user_wren,
  input  logic [3:0]               user_wstrb,
  input  logic [31:0]              user_wr_data,
  input  logic                     user_rden,
  output logic [31:0]              user_rd_data,
  output logic                     user_irq,
  output logic [NUM_CTRL*32-1:0]   ctrl_out,
  input  logic [NUM_STAT*32-1:0]   stat_in,
  input  logic [NUM_IRQ-1:0]       irq_src,
  input  logic                     fifo_wr_en,
  input  logic [31:0]              fifo_wr_data,
  output logic                     fifo_full
);

  localparam int          LW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] IRQ_VALID = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NUM_IRQ) - 32'd1);

  logic [7:0]             word;
  logic                   unused_addr_bits;
  logic [NUM_CTRL*32-1:0] ctrl_q, ctrl_d;
  logic [31:0]            status_q, status_d, mask_q, mask_d, src_q, src_ext, w1c;
  logic                   ovf_q, ovf_d, irq_q, rd_fifo_q, rd_fifo_d;
  logic [31:0]            rd_data_q, rd_data_d;
  logic                   fifo_pop, fifo_empty, fifo_full_w, fifo_drop;
  logic [31:0]            fifo_rd_data;
  logic [LW-1:0]          fifo_level;
  logic [16:0]            lvl_ext;
  logic [15:0]            lvl_sat;

  assign word             = user_addr[9:2];
  assign unused_addr_bits = ^{user_addr[31:10], user_addr[1:0]};
  assign src_ext          = 32'(irq_src);
  assign fifo_pop         = user_rden && (word == ADDR_FIFO_DATA);
  assign lvl_ext          = 17'(fifo_level);
  assign lvl_sat          = lvl_ext[16] ? 16'hFFFF : lvl_ext[15:0];

  xlite_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk_i       (user_clk),
    .rst_ni      (bus_rst_n),
    .push_i      (fifo_wr_en),
    .push_data_i (fifo_wr_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rd_data),
    .level_o     (fifo_level),
    .full_o      (fifo_full_w),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop)
  );

  always_comb begin
    ctrl_d    = ctrl_q;
    mask_d    = mask_q;
    w1c       = 32'h0;
    ovf_d     = ovf_q;
    rd_data_d = rd_data_q;
    rd_fifo_d = rd_fifo_q;
    if (user_wren) begin
      if (word == ADDR_IRQ_MASK)   mask_d = merge_bytes(mask_q, user_wr_data, user_wstrb) & IRQ_VALID;
      if (word == ADDR_IRQ_STATUS) w1c    = merge_bytes(32'h0, user_wr_data, user_wstrb);
      if (word == ADDR_FIFO_STAT && user_wstrb[2] && user_wr_data[FSTAT_OVF_BIT]) ovf_d = 1'b0;
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (word == ADDR_CTRL_BASE + 8'(k))
          ctrl_d[32*k +: 32] = merge_bytes(ctrl_q[32*k +: 32], user_wr_data, user_wstrb);
      end
    end
    if (fifo_drop) ovf_d = 1'b1;
    // A new rising edge outranks a W1C clear landing in the same cycle.
    status_d = (status_q & ~w1c) | (src_ext & ~src_q);

    // Reads see the register state from before any write in the same cycle.
    if (user_rden) begin
      rd_fifo_d = (word == ADDR_FIFO_DATA);
      rd_data_d = 32'h0;
      case (word)
        ADDR_ID:         rd_data_d = VERSION;
        ADDR_IRQ_STATUS: rd_data_d = status_q;
        ADDR_IRQ_MASK:   rd_data_d = mask_q;
        ADDR_FIFO_STAT: begin
          rd_data_d[FSTAT_LEVEL_W-1:0] = lvl_sat;
          rd_data_d[FSTAT_EMPTY_BIT]   = fifo_empty;
          rd_data_d[FSTAT_FULL_BIT]    = fifo_full_w;
          rd_data_d[FSTAT_OVF_BIT]     = ovf_q;
        end
        default: ;
      endcase
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (word == ADDR_CTRL_BASE + 8'(k)) rd_data_d = ctrl_q[32*k +: 32];
      end
      for (int k = 0; k < NUM_STAT; k++) begin
        if (word == ADDR_STAT_BASE + 8'(k)) rd_data_d = stat_in[32*k +: 32];
      end
    end
  end

  always_ff @(posedge user_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      ctrl_q    <= CTRL_RESET;
      status_q  <= '0;
      mask_q    <= '0;
      src_q     <= '0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      rd_data_q <= '0;
      rd_fifo_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      mask_q    <= mask_d;
      src_q     <= src_ext;
      ovf_q     <= ovf_d;
      irq_q     <= |(status_q & mask_q);
      rd_data_q <= rd_data_d;
      rd_fifo_q <= rd_fifo_d;
    end
  end

  assign user_rd_data = rd_fifo_q ? fifo_rd_data : rd_data_q;
  assign user_irq     = irq_q;
  assign ctrl_out     = ctrl_q;
  assign fifo_full    = fifo_full_w;

endmodule

// File: tb/tb_xillybus_lite_regbank.sv
// tb/tb_xillybus_lite_regbank.sv - directed bench with a queue-based reference model of the register bank
module tb_xillybus_lite_regbank;

  localparam int NUM_CTRL = 8;
  localparam int NUM_STAT = 8;
  localparam int NUM_IRQ  = 16;
  localparam int DEPTH    = 64;
  localparam logic [NUM_CTRL*32-1:0] CTRL_RESET = {192'h0, 32'h1234_5678, 32'h0};
  localparam logic [31:0] VERSION = 32'h0001_0000;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [31:0]            addr, wdata, fdata;
  logic                   wren, rden, fwen;
  logic [3:0]             wstrb;
  logic [31:0]            rdata;
  logic                   irq, ffull;
  logic [NUM_CTRL*32-1:0] ctrl_out;
  logic [NUM_STAT*32-1:0] stat_in;
  logic [NUM_IRQ-1:0]     irq_src;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xillybus_lite_regbank #(
    .NUM_CTRL(NUM_CTRL), .NUM_STAT(NUM_STAT), .NUM_IRQ(NUM_IRQ),
    .FIFO_DEPTH(DEPTH), .CTRL_RESET(CTRL_RESET), .VERSION(VERSION)
  ) dut (
    .user_clk(clk), .bus_rst_n(rst_n), .user_addr(addr), .user_wren(wren),
    .user_wstrb(wstrb), .user_wr_data(wdata), .user_rden(rden), .user_rd_data(rdata),
    .user_irq(irq), .ctrl_out(ctrl_out), .stat_in(stat_in), .irq_src(irq_src),
    .fifo_wr_en(fwen), .fifo_wr_data(fdata), .fifo_full(ffull)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: state as plain arrays and a queue, advanced once per rising edge.
  logic [31:0] m_ctrl [NUM_CTRL];
  logic [31:0] m_status, m_mask, m_prev, m_rd;
  logic        m_irq, m_ovf;
  logic [31:0] m_q [$];

  always @(posedge clk) begin : model
    logic [7:0]   w;
    int           pre_size;
    logic         popped;
    logic [31:0]  rv, bm, src;
    logic [255:0] pk;
    if (!rst_n) begin
      for (int k = 0; k < NUM_CTRL; k++) m_ctrl[k] = CTRL_RESET[32*k +: 32];
      m_status = 0; m_mask = 0; m_prev = 0; m_rd = 0; m_irq = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      w        = addr[9:2];
      pre_size = m_q.size();
      popped   = 1'b0;
      bm       = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
      src      = 32'(irq_src);
      m_irq    = |(m_status & m_mask);
      if (rden) begin
        rv = 0;
        if (w == 8'h00) rv = VERSION;
        else if (w == 8'h01) rv = m_status;
        else if (w == 8'h02) rv = m_mask;
        else if (w == 8'h03) rv = {13'd0, m_ovf, pre_size == DEPTH, pre_size == 0, 16'(pre_size)};
        else if (w == 8'h04) begin
          if (pre_size > 0) begin rv = m_q.pop_front(); popped = 1'b1; end
        end
        else if (w >= 8'h10 && w < 8'h10 + NUM_CTRL) rv = m_ctrl[w - 8'h10];
        else if (w >= 8'h20 && w < 8'h20 + NUM_STAT) rv = stat_in[32*(w - 8'h20) +: 32];
        m_rd = rv;
      end
      if (wren) begin
        if (w == 8'h01) m_status = m_status & ~(wdata & bm);
        if (w == 8'h02) m_mask = ((m_mask & ~bm) | (wdata & bm)) & 32'h0000_FFFF;
        if (w == 8'h03 && wstrb[2] && wdata[18]) m_ovf = 1'b0;
        if (w >= 8'h10 && w < 8'h10 + NUM_CTRL)
          m_ctrl[w - 8'h10] = (m_ctrl[w - 8'h10] & ~bm) | (wdata & bm);
      end
      if (fwen) begin
        if (pre_size < DEPTH || popped) m_q.push_back(fdata);
        else m_ovf = 1'b1;
      end
      m_status = m_status | (src & ~m_prev);
      m_prev   = src;
    end
    #2;
    for (int k = 0; k < NUM_CTRL; k++) pk[32*k +: 32] = m_ctrl[k];
    check("cmp_irq", irq, m_irq);
    check("cmp_full", ffull, m_q.size() == DEPTH);
    check("cmp_ctrl_out", ctrl_out, pk);
    check("cmp_rd_data", rdata, m_rd);
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wdata = d; wstrb = s; wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; rden = 1'b1;
    @(negedge clk);
    rden = 1'b0;
    d = rdata;
  endtask

  task automatic push(input logic [31:0] d);
    fdata = d; fwen = 1'b1;
    @(negedge clk);
    fwen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    for (int k = 0; k < NUM_STAT; k++) stat_in[32*k +: 32] = 32'hC0DE_0000 + 32'(k);
    rst_n = 1'b0; addr = 0; wdata = 0; wstrb = 0; wren = 0; rden = 0;
    fwen = 0; fdata = 0; irq_src = 0;
    repeat (2) @(negedge clk);
    check("reset_irq", irq, 1'b0);
    check("reset_full", ffull, 1'b0);
    check("reset_rd_data", rdata, 32'h0);
    check("reset_ctrl_out", ctrl_out, CTRL_RESET);
    rst_n = 1'b1;
    @(negedge clk);

    rd(32'h00, v); check("id", v, 32'h0001_0000);
    rd(32'h08, v); check("mask_reset", v, 32'h0);
    rd(32'h40, v); check("ctrl0_reset", v, 32'h0);
    rd(32'h44, v); check("ctrl1_reset", v, 32'h1234_5678);
    rd(32'h88, v); check("stat2", v, 32'hC0DE_0002);
    rd(32'hA0, v); check("stat_out_of_range", v, 32'h0);

    wr(32'h40, 32'hAABB_CCDD, 4'b0101);
    check("ctrl0_out_strobed", ctrl_out[31:0], 32'h00BB_00DD);
    rd(32'h40, v); check("ctrl0_strobed", v, 32'h00BB_00DD);
    rd(32'hFFFF_FC40, v); check("addr_high_ignored", v, 32'h00BB_00DD);
    rd(32'h1FC, v); check("unmapped_7f", v, 32'h0);

    wr(32'h08, 32'hFFFF_0008, 4'hF);
    rd(32'h08, v); check("mask_upper_ro", v, 32'h0000_0008);
    irq_src = 16'h0008;
    @(negedge clk); check("irq_after_one", irq, 1'b0);
    @(negedge clk); check("irq_after_two", irq, 1'b1);
    irq_src = 16'h0000;
    wr(32'h04, 32'h8, 4'h1);
    @(negedge clk); check("irq_cleared", irq, 1'b0);
    rd(32'h04, v); check("status_cleared", v, 32'h0);
    irq_src = 16'h0008;
    wr(32'h04, 32'h8, 4'h1);
    irq_src = 16'h0000;
    rd(32'h04, v); check("edge_beats_w1c", v, 32'h8);
    wr(32'h04, 32'hFFFF_FFFF, 4'b1110);
    rd(32'h04, v); check("w1c_lane_off", v, 32'h8);
    wr(32'h04, 32'hFFFF_FFFF, 4'hF);
    rd(32'h04, v); check("w1c_all", v, 32'h0);

    push(32'h11); push(32'h22); push(32'h33);
    rd(32'h0C, v); check("fstat_level3", v, 32'h0000_0003);
    rd(32'h10, v); check("pop1", v, 32'h11);
    rd(32'h10, v); check("pop2", v, 32'h22);
    rd(32'h10, v); check("pop3", v, 32'h33);
    rd(32'h10, v); check("pop_empty", v, 32'h0);
    rd(32'h0C, v); check("fstat_empty", v, 32'h0001_0000);

    for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i));
    check("full_flag", ffull, 1'b1);
    rd(32'h0C, v); check("fstat_full", v, 32'h0002_0040);
    push(32'hDEAD);
    rd(32'h0C, v); check("fstat_ovf", v, 32'h0006_0040);
    fdata = 32'hBEEF; fwen = 1'b1;
    rd(32'h10, v);
    fwen = 1'b0;
    check("pushpop_full_head", v, 32'h100);
    rd(32'h0C, v); check("fstat_still_full", v, 32'h0006_0040);
    wr(32'h0C, 32'h0004_0000, 4'b0100);
    rd(32'h0C, v); check("ovf_cleared", v, 32'h0002_0040);
    rd(32'h10, v); check("drain_first", v, 32'h101);
    for (int i = 1; i < DEPTH; i++) rd(32'h10, v);
    check("drain_last", v, 32'hBEEF);
    rd(32'h0C, v); check("fstat_drained", v, 32'h0001_0000);

    push(32'h51); push(32'h52); push(32'h53); push(32'h54);
    irq_src = 16'h0008;
    @(negedge clk);
    irq_src = 16'h0000;
    @(negedge clk); check("irq_pending", irq, 1'b1);
    fdata = 32'h55; fwen = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_irq", irq, 1'b0);
    check("midrst_full", ffull, 1'b0);
    check("midrst_rd_data", rdata, 32'h0);
    check("midrst_ctrl_out", ctrl_out, CTRL_RESET);
    fwen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h0C, v); check("post_rst_fstat", v, 32'h0001_0000);
    rd(32'h04, v); check("post_rst_status", v, 32'h0);
    rd(32'h08, v); check("post_rst_mask", v, 32'h0);
    rd(32'h40, v); check("post_rst_ctrl0", v, 32'h0);
    rd(32'h10, v); check("post_rst_pop", v, 32'h0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
